// File: rtl/speech_seq_ctrl.sv
// SPI-fed speech frame sequencer: receives NBYTES audio bytes, kicks the processing
// engine, then shifts the engine's result byte back out on the next ss frame.
module speech_seq_ctrl #(
  parameter int NBYTES      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sck,
  input  logic       ss,
  input  logic       sdi,
  output logic       sdo,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_last,
  output logic       proc_start,
  input  logic       proc_done,
  input  logic [7:0] result,
  output logic       busy,
  output logic       err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    PROC    = 3'd2,
    WAIT_TX = 3'd3,
    SEND    = 3'd4
  } state_e;

  localparam logic [7:0] LAST_BYTE = 8'(NBYTES - 1);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic [SYNC_STAGES:0]   settle_q, settle_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   ss_prev_q, ss_prev_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             byte_cnt_q, byte_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_last_q, rx_last_d;
  logic                   proc_start_q, proc_start_d;
  logic [7:0]             tx_q, tx_d;
  logic                   err_q, err_d;

  logic sck_s, ss_s, sdi_s, settled;
  logic sck_rise, sck_fall, ss_rise, ss_fall;
  logic byte_done;

  // Edges are masked until the synchronizers have refilled after reset, so a level
  // that was already high when reset released is never mistaken for an edge.
  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
    ss_sync_d  = {ss_sync_q[SYNC_STAGES-2:0], ss};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    settle_d   = {settle_q[SYNC_STAGES-1:0], 1'b1};
    sck_s      = sck_sync_q[SYNC_STAGES-1];
    ss_s       = ss_sync_q[SYNC_STAGES-1];
    sdi_s      = sdi_sync_q[SYNC_STAGES-1];
    sck_prev_d = sck_s;
    ss_prev_d  = ss_s;
    settled    = settle_q[SYNC_STAGES];
    sck_rise   = settled & sck_s & ~sck_prev_q;
    sck_fall   = settled & ~sck_s & sck_prev_q;
    ss_rise    = settled & ss_s & ~ss_prev_q;
    ss_fall    = settled & ~ss_s & ss_prev_q;
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_last_d    = 1'b0;
    proc_start_d = 1'b0;
    tx_d         = tx_q;
    err_d        = err_q;
    byte_done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ss_rise) begin
          state_d    = RECV;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 8'd0;
          shift_d    = 8'd0;
        end
      end
      RECV: begin
        byte_done = sck_rise && (bit_cnt_q == 3'd7);
        // Completing the final byte wins over a simultaneous ss drop.
        if (byte_done && (byte_cnt_q == LAST_BYTE)) begin
          rx_data_d    = {shift_q[6:0], sdi_s};
          rx_valid_d   = 1'b1;
          rx_last_d    = 1'b1;
          proc_start_d = 1'b1;
          bit_cnt_d    = 3'd0;
          byte_cnt_d   = 8'd0;
          shift_d      = 8'd0;
          state_d      = PROC;
        end else if (ss_fall) begin
          err_d      = 1'b1;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 8'd0;
          shift_d    = 8'd0;
          state_d    = IDLE;
        end else if (sck_rise) begin
          shift_d   = {shift_q[6:0], sdi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_done) begin
            rx_data_d  = shift_d;
            rx_valid_d = 1'b1;
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end
      PROC: begin
        if (proc_done) begin
          tx_d    = result;
          state_d = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (ss_rise) begin
          bit_cnt_d = 3'd0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (sck_fall && (bit_cnt_q == 3'd7)) begin
          tx_d      = 8'd0;
          bit_cnt_d = 3'd0;
          state_d   = IDLE;
        end else if (ss_fall) begin
          err_d     = 1'b1;
          tx_d      = 8'd0;
          bit_cnt_d = 3'd0;
          state_d   = IDLE;
        end else if (sck_fall) begin
          tx_d      = {tx_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sck_sync_q   <= '0;
      ss_sync_q    <= '0;
      sdi_sync_q   <= '0;
      settle_q     <= '0;
      sck_prev_q   <= 1'b0;
      ss_prev_q    <= 1'b0;
      bit_cnt_q    <= 3'd0;
      byte_cnt_q   <= 8'd0;
      shift_q      <= 8'd0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_last_q    <= 1'b0;
      proc_start_q <= 1'b0;
      tx_q         <= 8'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sck_sync_q   <= sck_sync_d;
      ss_sync_q    <= ss_sync_d;
      sdi_sync_q   <= sdi_sync_d;
      settle_q     <= settle_d;
      sck_prev_q   <= sck_prev_d;
      ss_prev_q    <= ss_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_last_q    <= rx_last_d;
      proc_start_q <= proc_start_d;
      tx_q         <= tx_d;
      err_q        <= err_d;
    end
  end

  // The tx register shifts left, so its MSB is always the bit currently on the wire.
  assign sdo        = (state_q == SEND) & tx_q[7];
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_last    = rx_last_q;
  assign proc_start = proc_start_q;
  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_speech_seq_ctrl.sv
// Scoreboard bench for speech_seq_ctrl: stimulus pushes expected rx bytes and sdo bits,
// monitors pop and compare when the DUT pulses rx_valid or the master samples sdo.
module tb_speech_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sck = 1'b0;
  logic       ss = 1'b0;
  logic       sdi = 1'b0;
  logic       sdo;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_last;
  logic       proc_start;
  logic       proc_done = 1'b0;
  logic [7:0] result = 8'd0;
  logic       busy;
  logic       err;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int ps_cnt = 0;
  bit tx_mon_en = 1'b0;
  logic [7:0] eng_result = 8'd0;
  logic [8:0] exp_rx[$];
  logic       exp_tx[$];

  speech_seq_ctrl #(.NBYTES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss), .sdi(sdi), .sdo(sdo),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last),
    .proc_start(proc_start), .proc_done(proc_done), .result(result),
    .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // rx monitor and proc_start counter
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid) begin
        rx_cnt++;
        if (exp_rx.size() == 0) begin
          chk("unexpected_rx_valid", {23'd0, rx_last, rx_data}, 32'h1ff);
        end else begin
          logic [8:0] e;
          e = exp_rx.pop_front();
          chk("rx_data", {24'd0, rx_data}, {24'd0, e[7:0]});
          chk("rx_last", {31'd0, rx_last}, {31'd0, e[8]});
        end
      end
      if (proc_start) ps_cnt++;
    end
  end

  // sdo monitor: the master samples on its own rising sck edge
  always @(posedge sck) begin
    if (tx_mon_en) begin
      if (exp_tx.size() == 0) begin
        chk("unexpected_sdo_sample", 32'd0, 32'd1);
      end else begin
        logic e;
        e = exp_tx.pop_front();
        chk("sdo_bit", {31'd0, sdo}, {31'd0, e});
      end
    end
  end

  // processing engine model: done with eng_result two cycles after proc_start
  always begin
    @(negedge clk);
    if (reset_n && proc_start) begin
      repeat (2) @(negedge clk);
      proc_done = 1'b1;
      result    = eng_result;
      @(negedge clk);
      proc_done = 1'b0;
      result    = 8'd0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      if (state_dbg == s) break;
      @(negedge clk);
    end
    chk("wait_state", {29'd0, state_dbg}, {29'd0, s});
  endtask

  task automatic rx_frame(input logic [31:0] w, input int nbits, input bit drop);
    ss = 1'b1;
    cyc(6);
    for (int i = 0; i < nbits; i++) begin
      sdi = w[31-i];
      cyc(4);
      sck = 1'b1;
      cyc(4);
      sck = 1'b0;
    end
    sdi = 1'b0;
    cyc(6);
    if (drop) ss = 1'b0;
    cyc(6);
  endtask

  task automatic tx_bits(input logic [7:0] b, input int n);
    tx_mon_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(b[7-i]);
      sck = 1'b1;
      cyc(8);
      sck = 1'b0;
      cyc(8);
    end
    tx_mon_en = 1'b0;
  endtask

  task automatic tx_full(input logic [7:0] b);
    ss = 1'b0;
    cyc(6);
    ss = 1'b1;
    cyc(8);
    chk("send_entry", {29'd0, state_dbg}, 32'd4);
    tx_bits(b, 8);
    cyc(4);
    chk("tx_end_state", {29'd0, state_dbg}, 32'd0);
    chk("tx_end_busy", {31'd0, busy}, 32'd0);
    chk("tx_end_sdo", {31'd0, sdo}, 32'd0);
    ss = 1'b0;
    cyc(6);
  endtask

  initial begin
    int rx_before;
    cyc(2);
    chk("rst_state", {29'd0, state_dbg}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_sdo", {31'd0, sdo}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_proc_start", {31'd0, proc_start}, 32'd0);
    reset_n = 1'b1;
    cyc(6);

    // frame 0x12 0x34 0x56 0x78, engine answers 0xA5
    eng_result = 8'hA5;
    exp_rx.push_back({1'b0, 8'h12});
    exp_rx.push_back({1'b0, 8'h34});
    exp_rx.push_back({1'b0, 8'h56});
    exp_rx.push_back({1'b1, 8'h78});
    rx_frame(32'h12345678, 32, 1'b1);
    wait_state(3'd3, 60);
    chk("proc_start_once", ps_cnt, 32'd1);
    chk("rx_cnt_frame1", rx_cnt, 32'd4);
    tx_full(8'hA5);

    // ss dropped after 13 bits: one byte delivered, error, back to idle
    rx_before = rx_cnt;
    exp_rx.push_back({1'b0, 8'hC3});
    rx_frame({8'hC3, 5'b10101, 19'd0}, 13, 1'b1);
    chk("abort_rx_cnt", rx_cnt - rx_before, 32'd1);
    chk("abort_err", {31'd0, err}, 32'd1);
    chk("abort_state", {29'd0, state_dbg}, 32'd0);

    // next full frame still completes, err stays sticky
    eng_result = 8'h3C;
    exp_rx.push_back({1'b0, 8'h01});
    exp_rx.push_back({1'b0, 8'h02});
    exp_rx.push_back({1'b0, 8'h03});
    exp_rx.push_back({1'b1, 8'h04});
    rx_frame(32'h01020304, 32, 1'b1);
    wait_state(3'd3, 60);
    chk("proc_start_frame2", ps_cnt, 32'd2);
    chk("err_sticky", {31'd0, err}, 32'd1);
    tx_full(8'h3C);

    // ss still high when processing ends: needs a fresh ss edge
    eng_result = 8'h5A;
    exp_rx.push_back({1'b0, 8'h11});
    exp_rx.push_back({1'b0, 8'h22});
    exp_rx.push_back({1'b0, 8'h33});
    exp_rx.push_back({1'b1, 8'h44});
    rx_frame(32'h11223344, 32, 1'b0);
    wait_state(3'd3, 60);
    cyc(20);
    chk("wait_tx_hold", {29'd0, state_dbg}, 32'd3);
    for (int i = 0; i < 2; i++) begin
      sck = 1'b1; cyc(8); sck = 1'b0; cyc(8);
    end
    chk("wait_tx_sck_ignored", {29'd0, state_dbg}, 32'd3);
    ss = 1'b0;
    cyc(8);
    chk("wait_tx_ss_low", {29'd0, state_dbg}, 32'd3);
    ss = 1'b1;
    cyc(8);
    chk("wait_tx_to_send", {29'd0, state_dbg}, 32'd4);
    tx_bits(8'h5A, 3);
    chk("send_bit3_sdo", {31'd0, sdo}, 32'd1);

    // reset during SEND bit 3
    reset_n = 1'b0;
    #1;
    chk("midreset_sdo", {31'd0, sdo}, 32'd0);
    chk("midreset_err", {31'd0, err}, 32'd0);
    chk("midreset_state", {29'd0, state_dbg}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    cyc(3);
    reset_n = 1'b1;
    cyc(4);
    for (int i = 0; i < 8; i++) begin
      sck = 1'b1; cyc(8); sck = 1'b0; cyc(8);
    end
    chk("post_reset_no_edge", {29'd0, state_dbg}, 32'd0);
    chk("post_reset_err", {31'd0, err}, 32'd0);
    ss = 1'b0;
    cyc(8);

    // fresh frame after reset
    eng_result = 8'h81;
    exp_rx.push_back({1'b0, 8'hDE});
    exp_rx.push_back({1'b0, 8'hAD});
    exp_rx.push_back({1'b0, 8'hBE});
    exp_rx.push_back({1'b1, 8'hEF});
    rx_frame(32'hDEADBEEF, 32, 1'b1);
    wait_state(3'd3, 60);
    chk("proc_start_final", ps_cnt, 32'd4);
    tx_full(8'h81);

    chk("exp_rx_drained", exp_rx.size(), 32'd0);
    chk("exp_tx_drained", exp_tx.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/speech_seq_ctrl.md
SPEECH_SEQ_CTRL -- requirements
Module: speech_seq_ctrl

Interface
REQ-001 Parameter NBYTES, default 4, bytes per received audio frame (legal range 1..255).
REQ-002 Parameter SYNC_STAGES, default 2, flip-flop depth of the input synchronizers (minimum 2).
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 sck  in  1  SPI clock from master, asynchronous to clk.
REQ-006 ss  in  1  SPI frame select from master, active-high, asynchronous.
REQ-007 sdi  in  1  SPI serial data in, MSB first.
REQ-008 sdo  out  1  SPI serial data out, MSB first.
REQ-009 rx_data  out  8  last fully received byte.
REQ-010 rx_valid  out  1  one-cycle pulse when rx_data updates.
REQ-011 rx_last  out  1  high together with rx_valid on byte NBYTES of a frame.
REQ-012 proc_start  out  1  one-cycle pulse that starts the processing engine.
REQ-013 proc_done  in  1  engine completion, level or pulse, sampled only in PROC.
REQ-014 result  in  8  engine output byte, valid while proc_done is high.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 err  out  1  sticky protocol-error flag.
REQ-017 state_dbg  out  3  current state encoding for the LED bar.

Function
REQ-018 sck, ss and sdi SHALL each pass through a SYNC_STAGES synchronizer; edge detection SHALL use the synchronized sck and ss.
REQ-019 States and encodings SHALL be IDLE=0, RECV=1, PROC=2, WAIT_TX=3, SEND=4; unused encodings SHALL go to IDLE.
REQ-020 IDLE: on synced ss rising edge -> RECV; bit counter and byte counter cleared.
REQ-021 RECV: each synced sck rising edge SHALL shift synced sdi into the shift register LSB, MSB-first order.
REQ-022 On the 8th captured bit, rx_data SHALL load the completed byte and rx_valid SHALL pulse in the next clk cycle; the bit counter SHALL wrap to 0.
REQ-023 After byte NBYTES, rx_last SHALL pulse with rx_valid and the state SHALL go to PROC in the same cycle.
REQ-024 Synced ss falling in RECV before byte NBYTES completes: -> IDLE, err set, partial byte discarded, no rx_valid.
REQ-025 PROC: proc_start SHALL pulse exactly once, in the first PROC cycle; sck and ss activity SHALL be ignored.
REQ-026 PROC: when proc_done=1, result SHALL be latched into the tx register -> WAIT_TX; proc_done in the proc_start cycle SHALL be accepted.
REQ-027 WAIT_TX: on synced ss rising edge -> SEND; ss already high on entry SHALL NOT trigger (edge required).
REQ-028 SEND: sdo SHALL present tx[7] from the first SEND cycle; each synced sck falling edge SHALL advance to the next bit.
REQ-029 SEND: the 8th synced sck falling edge SHALL end the byte -> IDLE; sdo SHALL return to 0.
REQ-030 Synced ss falling in SEND before the 8th falling edge: -> IDLE, err set.
REQ-031 sdo SHALL be 0 in every state except SEND.
REQ-032 Simultaneous ss falling and 8th-bit sck edge on the last RECV byte: the byte completion SHALL take priority (-> PROC, no err).
REQ-033 err SHALL clear only on reset; it SHALL NOT block further frames.

Reset
REQ-034 reset_n low SHALL immediately force state IDLE and clear sdo, rx_data, rx_valid, rx_last, proc_start, busy, err, all counters, the shift register, the tx register and the synchronizer flops to 0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame; after release, a new transfer SHALL require a fresh ss rising edge.

Verification
REQ-036 NBYTES=4; frame 0x12,0x34,0x56,0x78 -> four rx_valid pulses with matching rx_data, rx_last only on 0x78, one proc_start.
REQ-037 proc_done with result=0xA5 two cycles after proc_start; new ss frame with 8 sck -> sdo bits 1,0,1,0,0,1,0,1, then IDLE, busy=0.
REQ-038 ss dropped after 13 bits of a frame -> rx_valid count 1, err=1, state IDLE; next full frame completes normally.
REQ-039 ss high already when PROC ends -> stays in WAIT_TX until ss goes low then high; only then SEND.
REQ-040 reset_n pulsed low during SEND bit 3 -> sdo=0, err=0, state_dbg=0 immediately; sck toggling without an ss edge -> no state change.
